// File: rtl/ghost_pkg.sv
// ghost_pkg: definitions shared by the boot-time ROM loader and its helpers.
//   ld_state_t : loader FSM state encoding, also visible on the loader debug port
//   RAM_AW     : system RAM byte address width (4 KiB)
//   ROM_AW     : flash byte address width
package ghost_pkg;

  localparam int RAM_AW = 12;
  localparam int ROM_AW = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    WAIT_LO = 3'd2,
    WAIT_HI = 3'd3,
    WRITE   = 3'd4,
    DONE    = 3'd5,
    ERROR   = 3'd6
  } ld_state_t;

endpackage

// File: rtl/ld_timer.sv
// ld_timer: loadable down-counter with a zero flag.
//   clk, reset_n : clock, asynchronous active-low reset (count clears to 0)
//   load         : load load_val (has priority over dec)
//   load_val     : reload value
//   dec          : decrement by one; the counter stops at zero
//   zero         : high while the count is zero
module ld_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/rom_loader.sv
// rom_loader: boot-time copier. On a start pulse it copies LENGTH bytes from
// flash (starting at SRC_BASE) into system RAM (starting at DST_BASE, wrapping
// mod 4096), one byte at a time through the flash reader, then flags done.
// A byte that does not arrive within TIMEOUT cycles ends the copy with error.
//
// Ports:
//   clk, reset_n  : clock (all state on posedge), asynchronous active-low reset
//   start         : one-cycle pulse, accepted only in IDLE
//   busy          : high from start accept until done/error
//   done, error   : sticky status, cleared by the next accepted start
//   rom_addr      : byte address to the flash reader
//   rom_dout      : byte from the flash reader
//   rom_dready    : flash reader data valid (level)
//   ram_addr, ram_din, ram_we : RAM write port, one ram_we cycle per byte
//   csum          : running mod-256 sum of written bytes (0 unless enabled)
//   dbg_state     : current FSM state (ld_state_t encoding)
//
// Build option: define ROM_LOADER_CSUM_EN to include the checksum adder;
// without it csum is tied to zero.
//
// Flash handshake: the reader has no ready input. A new read is requested by
// changing rom_addr; the reader then drops rom_dready, and raises it again
// with rom_dout valid once the byte is fetched. The loader therefore waits
// for dready low (address accepted) before it waits for dready high, so a
// dready still high from the previous byte is never taken as data. Each byte
// uses a distinct address, so every byte forces a fresh read.
module rom_loader
  import ghost_pkg::*;
#(
  parameter logic [ROM_AW-1:0] SRC_BASE = 16'h0000,
  parameter logic [RAM_AW-1:0] DST_BASE = 12'h200,
  parameter logic [12:0]       LENGTH   = 13'd3584,
  parameter logic [15:0]       TIMEOUT  = 16'd2048
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_dout,
  input  logic              rom_dready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_we,
  output logic [7:0]        csum,
  output logic [2:0]        dbg_state
);

  // The timer is loaded in ARM and counts down once per wait cycle; loading
  // TIMEOUT-1 makes the zero flag show up on the TIMEOUT-th wait cycle, so a
  // byte gets exactly TIMEOUT cycles across WAIT_LO and WAIT_HI combined.
  // TIMEOUT must be at least 1.
  localparam logic [15:0] TMO_RELOAD = TIMEOUT - 16'd1;

  ld_state_t   state;
  logic [12:0] n;
  logic [12:0] n_next;
  logic        tmo_load;
  logic        tmo_dec;
  logic        tmo_zero;

  assign n_next    = n + 13'd1;
  assign tmo_load  = (state == ARM);
  assign tmo_dec   = (state == WAIT_LO) || (state == WAIT_HI);
  assign dbg_state = state;

  ld_timer #(
    .W(16)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmo_load),
    .load_val (TMO_RELOAD),
    .dec      (tmo_dec),
    .zero     (tmo_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      rom_addr <= '1;
      ram_addr <= DST_BASE;
      ram_din  <= 8'h00;
      ram_we   <= 1'b0;
      n        <= 13'd0;
    end else begin
      // ram_we is raised on entry to WRITE and dropped on the following edge.
      ram_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            done  <= 1'b0;
            error <= 1'b0;
            busy  <= 1'b1;
            n     <= 13'd0;
            state <= (LENGTH == 13'd0) ? DONE : ARM;
          end
        end
        ARM: begin
          rom_addr <= SRC_BASE + {3'b000, n};
          state    <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!rom_dready) begin
            state <= WAIT_HI;
          end else if (tmo_zero) begin
            busy  <= 1'b0;
            error <= 1'b1;
            state <= ERROR;
          end
        end
        WAIT_HI: begin
          if (rom_dready) begin
            ram_din  <= rom_dout;
            ram_addr <= DST_BASE + n[11:0];
            ram_we   <= 1'b1;
            state    <= WRITE;
          end else if (tmo_zero) begin
            busy  <= 1'b0;
            error <= 1'b1;
            state <= ERROR;
          end
        end
        WRITE: begin
          n     <= n_next;
          state <= (n_next == LENGTH) ? DONE : ARM;
        end
        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        ERROR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ROM_LOADER_CSUM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csum <= 8'h00;
    end else if ((state == IDLE) && start) begin
      csum <= 8'h00;
    end else if (state == WRITE) begin
      csum <= csum + ram_din;
    end
  end
`else
  assign csum = 8'h00;
`endif

endmodule
